issue_controller: RTL
=====================

Name: issue_controller

Overview:
- In-order issue stage of the Tomasulo core. Sits between the instruction queue (16-bit instructions, `instOutEn`/`instOut`, throttled by `disponivel`) and the reservation stations.
- Decodes each instruction and allocates a free reservation-station slot of the right class (adder or load/store).
- Reads operand producer tags from an internal register-status table, renames the destination, and stalls the queue through a 2-entry skid buffer when no slot is free.
- Tracks slot busy state and clears tags on CDB broadcasts.

Parameters:
- NUM_ADD, 3, number of adder reservation-station slots (ADD/SUB).
- NUM_LS, 3, number of load/store buffer slots (LD/SD).
- TAG_W, 3, tag width; must satisfy NUM_ADD+NUM_LS < 2**TAG_W.

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- disponivel  out  1  to queue: fetch permitted this cycle.
- instInEn  in  1  queue output valid.
- instIn  in  16  instruction word {op[15:12], f2[11:8], f1[7:4], f0[3:0]}.
- cdbEn  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  tag of completing ADD/SUB/LD slot.
- stDoneEn  in  1  store completion valid.
- stDoneTag  in  TAG_W  tag of completing SD slot.
- issueEn  out  1  one-cycle issue pulse.
- issueTag  out  TAG_W  allocated slot tag.
- issueOp  out  2  0=ADD, 1=SUB, 2=SD, 3=LD.
- issueRd  out  4  destination register (SD: 0).
- issueRj, issueRk  out  4 each  source register indices, for register-file read.
- issueQj, issueQk  out  TAG_W each  producer tags; 0 means value ready.
- issueImm  out  4  offset field f1 (LD/SD), else 0.
- illegalEn  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Tags: 0 means "no producer". Adder slots use tags 1..NUM_ADD; LS slots use tags NUM_ADD+1..NUM_ADD+NUM_LS.
- Decode:
  - ADD/SUB: Rd=f2, Rj=f1, Rk=f0.
  - SD: data reg Rj=f2, base Rk=f0, Imm=f1, no destination.
  - LD: Rd=f2, base Rk=f0, Imm=f1, Rj=0, Qj=0.
  - Opcodes 4..15 are illegal.
- `disponivel` is combinational: `!reset && count==0`. The queue emits one cycle after sampling `disponivel` high. The 2-entry buffer absorbs the one in-flight word that arrives after a stall begins.
- Each edge, candidate = buffer head if count>0, else `instIn` when `instInEn` (bypass).
- Issue happens if the candidate's class has a free slot. Allocation takes the lowest-index free slot of that class.
- Issue outputs are registered: `issueEn` is high for the cycle after the deciding edge. Latency from a bypassed arrival to `issueEn` is 1 cycle.
- If the candidate cannot issue, an arriving `instIn` is pushed into the buffer.
  - If the head issued and an arrival occurs on the same edge, pop and push together (count unchanged).
  - Strict program order; a push at count==2 cannot occur by construction; the assertion checker flags it.
- Illegal candidate: consumed without a slot, `illegalEn` pulses the next cycle, `issueEn` stays 0.
- Register-status table regTag[0..15], TAG_W each:
  - Qj = regTag[Rj], Qk = regTag[Rk], read at the issue edge.
  - If `cdbEn` is high and `cdbTag` equals the read tag on that same edge, report 0 (CDB bypass).
  - On issue of ADD/SUB/LD: regTag[Rd] <= issueTag.
  - On `cdbEn`: every regTag equal to `cdbTag` is cleared to 0.
  - Same-edge issue write to Rd overrides the CDB clear (WAW-correct).
- Busy bits, one per slot:
  - Set on allocation.
  - Cleared by `cdbEn` (`cdbTag`) or `stDoneEn` (`stDoneTag`).
  - A slot released at edge E is allocatable only from edge E+1.
  - Release of a non-busy slot is ignored.
- Reset (including mid-stall):
  - count=0, all regTag=0, all busy=0.
  - All issue* outputs = 0, `issueEn`=0, `illegalEn`=0.
  - `disponivel`=0 while reset is high.
  - An `instIn` arriving during reset is discarded.

Decomposition:
- Package `tomasulo_pkg`:
  - opcode constants OP_ADD/OP_SUB/OP_SD/OP_LD.
  - class enum {CLS_ADD, CLS_LS, CLS_ILL}.
  - decoded-instruction struct.
  - tag-base function (slot index to tag).
- Sub-module `issue_skid_buf`: 2-entry FIFO with push/pop/count, synchronous reset. The controller holds decode, the register-status table, busy bits and the allocator.

Test Plan:
- Reset, then 0x0312 (ADD R3,R1,R2), then 0x1531 (SUB R5,R3,R1) back-to-back → issueEn on 2 consecutive cycles; tags 1 and 2; second has Qj=1, Qk=0; `disponivel` stays 1.
- Four ADDs with no release → tags 1, 2, 3 issue; 4th is buffered, `disponivel` drops, the in-flight 5th gives count=2; cdbTag=2 → 4th issues with tag 2 the next cycle, 5th waits.
- regTag[3]=1 and `cdbEn`/`cdbTag`=1 on the same edge that SUB 0x1531 issues → issueQj=0; regTag[3]=0 and regTag[5]=new tag afterwards.
- ADD R1 (tag 1) then LD R1,0(R4) 0x3104 (tag 4) → then cdbTag=1 → regTag[1] remains 4; next reader of R1 gets Qk=4.
- SD 0x2306 → tag 4, issueRj=3, issueRk=6, issueImm=0, no regTag write; stDoneTag=4 → slot 4 reusable the next edge.
- 0xF000 → illegalEn pulse, no issueEn; reset asserted while count=2 → count=0, `disponivel`=1 on the first cycle after reset is released.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared decode types and helpers for the
// Tomasulo in-order issue stage.
package tomasulo_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SD  = 4'd2;
  localparam logic [3:0] OP_LD  = 4'd3;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_LS,
    CLS_ILL
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [1:0] op;
    logic       wr_rd;
    logic       use_j;
    logic [3:0] rd;
    logic [3:0] rj;
    logic [3:0] rk;
    logic [3:0] imm;
  } dec_t;

  function automatic int slot_tag(
    input int base,
    input int idx
  );
    return base + idx + 1;
  endfunction

  function automatic dec_t decode(
    input logic [15:0] w
  );
    dec_t d;
    d     = '0;
    d.cls = CLS_ILL;
    d.op  = w[13:12];
    unique case (1'b1)
      (w[15:12] == OP_ADD) ||
      (w[15:12] == OP_SUB): begin
        d.cls   = CLS_ADD;
        d.wr_rd = 1'b1;
        d.use_j = 1'b1;
        d.rd    = w[11:8];
        d.rj    = w[7:4];
        d.rk    = w[3:0];
      end
      w[15:12] == OP_SD: begin
        d.cls   = CLS_LS;
        d.use_j = 1'b1;
        d.rj    = w[11:8];
        d.rk    = w[3:0];
        d.imm   = w[7:4];
      end
      w[15:12] == OP_LD: begin
        d.cls   = CLS_LS;
        d.wr_rd = 1'b1;
        d.rd    = w[11:8];
        d.rk    = w[3:0];
        d.imm   = w[7:4];
      end
      default: d.cls = CLS_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/issue_skid_buf.sv
// Two-entry in-order skid buffer that holds
// instruction words while issue is stalled.
module issue_skid_buf #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] tail;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // The one-cycle fetch handshake bounds occupancy at two.
  a_no_ovf: assert property (
    @(posedge clock) disable iff (reset)
    !(push && !pop && count == 2'd2));

  a_no_unf: assert property (
    @(posedge clock) disable iff (reset)
    !(pop && count == 2'd0));

endmodule

// File: rtl/issue_controller.sv
// In-order issue: decode, slot allocation,
// register renaming and CDB tag clearing.
module issue_controller
  import tomasulo_pkg::*;
#(
  parameter int NUM_ADD = 3,
  parameter int NUM_LS  = 3,
  parameter int TAG_W   = 3
) (
  input  logic             clock,
  input  logic             reset,
  output logic             disponivel,
  input  logic             instInEn,
  input  logic [15:0]      instIn,
  input  logic             cdbEn,
  input  logic [TAG_W-1:0] cdbTag,
  input  logic             stDoneEn,
  input  logic [TAG_W-1:0] stDoneTag,
  output logic             issueEn,
  output logic [TAG_W-1:0] issueTag,
  output logic [1:0]       issueOp,
  output logic [3:0]       issueRd,
  output logic [3:0]       issueRj,
  output logic [3:0]       issueRk,
  output logic [TAG_W-1:0] issueQj,
  output logic [TAG_W-1:0] issueQk,
  output logic [3:0]       issueImm,
  output logic             illegalEn
);

  localparam int NS = NUM_ADD + NUM_LS;

  logic [1:0]       count;
  logic [15:0]      head;
  logic [15:0]      cand;
  logic             push;
  logic             pop;
  logic             have;
  logic             go;
  logic             ill;
  logic             hit;
  int               slot;
  dec_t             d;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] qj;
  logic [TAG_W-1:0] qk;
  logic [NS-1:0]    busy;
  logic [NS-1:0]    busy_nx;
  logic [TAG_W-1:0] reg_tag [16];

  issue_skid_buf #(.W(16)) u_buf (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (instIn),
    .head  (head),
    .count (count)
  );

  function automatic logic [TAG_W-1:0] fwd(
    input logic [TAG_W-1:0] t
  );
    return (cdbEn && cdbTag == t) ? '0 : t;
  endfunction

  assign disponivel = !reset && count == 2'd0;
  assign have = count != 2'd0 || instInEn;
  assign cand = count != 2'd0 ? head : instIn;
  assign d    = decode(cand);

  always_comb begin
    hit  = 1'b0;
    slot = 0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (!busy[s] &&
          ((d.cls == CLS_ADD && s < NUM_ADD) ||
           (d.cls == CLS_LS && s >= NUM_ADD))) begin
        hit  = 1'b1;
        slot = s;
      end
    end
  end

  assign go   = have && hit;
  assign ill  = have && d.cls == CLS_ILL;
  assign pop  = count != 2'd0 && (go || ill);
  assign push = !reset && instInEn &&
                (count != 2'd0 || !(go || ill));
  assign tag  = TAG_W'(slot_tag(0, slot));
  assign qj   = d.use_j ? fwd(reg_tag[d.rj]) : '0;
  assign qk   = fwd(reg_tag[d.rk]);

  // Busy reflects the pre-edge state, so a freed slot waits one edge.
  always_comb begin
    busy_nx = busy;
    for (int s = 0; s < NS; s++) begin
      if ((cdbEn &&
           cdbTag == TAG_W'(slot_tag(0, s))) ||
          (stDoneEn &&
           stDoneTag == TAG_W'(slot_tag(0, s))))
        busy_nx[s] = 1'b0;
      if (go && s == slot)
        busy_nx[s] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy      <= '0;
      issueEn   <= 1'b0;
      illegalEn <= 1'b0;
      issueTag  <= '0;
      issueOp   <= '0;
      issueRd   <= '0;
      issueRj   <= '0;
      issueRk   <= '0;
      issueQj   <= '0;
      issueQk   <= '0;
      issueImm  <= '0;
      for (int r = 0; r < 16; r++)
        reg_tag[r] <= '0;
    end else begin
      busy      <= busy_nx;
      issueEn   <= go;
      illegalEn <= ill;
      issueTag  <= go ? tag : '0;
      issueOp   <= go ? d.op : '0;
      issueRd   <= go ? d.rd : '0;
      issueRj   <= go ? d.rj : '0;
      issueRk   <= go ? d.rk : '0;
      issueQj   <= go ? qj : '0;
      issueQk   <= go ? qk : '0;
      issueImm  <= go ? d.imm : '0;
      // Rename wins over a same-edge CDB clear.
      for (int r = 0; r < 16; r++) begin
        if (go && d.wr_rd && d.rd == 4'(r))
          reg_tag[r] <= tag;
        else if (cdbEn && reg_tag[r] == cdbTag)
          reg_tag[r] <= '0;
      end
    end
  end

endmodule
